// File: rtl/pll_seq_pkg.sv
// Shared state encoding, default cycle constants and fault counter width for the
// PLL reset sequencer.
package pll_seq_pkg;

    typedef enum logic [1:0] {
        PLL_RST   = 2'd0,
        WAIT_LOCK = 2'd1,
        SETTLE    = 2'd2,
        RUN       = 2'd3
    } seq_state_e;

    localparam int unsigned DEF_PLL_RST_CYCLES      = 3;
    localparam int unsigned DEF_LOCK_STABLE_CYCLES  = 1024;
    localparam int unsigned DEF_LOCK_TIMEOUT_CYCLES = 65536;

    localparam int unsigned FAULT_W = 8;

    function automatic logic [FAULT_W-1:0] fault_sat_inc(input logic [FAULT_W-1:0] v);
        return (v == '1) ? v : v + {{(FAULT_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for level signals crossing into the local clock;
// both stages reset to 0.
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q, meta_d;
    logic [WIDTH-1:0] sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset / lock sequencer: pulses pll_rst, waits for stable lock, then releases core_reset.
// Optional lock timeout (with its fault counting) is built when PLL_LOCK_TIMEOUT_EN is defined.
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int unsigned PLL_RST_CYCLES      = DEF_PLL_RST_CYCLES,
    parameter int unsigned LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               pll_locked,
    input  logic               relock_req,
    output logic               pll_rst,
    output logic               core_reset,
    output logic               ready,
    output logic [1:0]         state,
    output logic [FAULT_W-1:0] fault_count
);

    localparam int unsigned RST_W = $clog2(PLL_RST_CYCLES) + 1;
    localparam int unsigned STB_W = $clog2(LOCK_STABLE_CYCLES) + 1;
    localparam logic [RST_W-1:0] RST_LAST = RST_W'(PLL_RST_CYCLES - 1);
    localparam logic [STB_W-1:0] STB_LAST = STB_W'(LOCK_STABLE_CYCLES - 1);

    logic locked_s;

    sync_2ff #(
        .WIDTH(1)
    ) u_lock_sync (
        .clock(clock),
        .reset(reset),
        .d    (pll_locked),
        .q    (locked_s)
    );

    seq_state_e         state_q, state_d;
    logic [RST_W-1:0]   rst_cnt_q, rst_cnt_d;
    logic [STB_W-1:0]   stb_cnt_q, stb_cnt_d;
    logic [FAULT_W-1:0] fault_q, fault_d;
    logic               pll_rst_q, pll_rst_d;
    logic               core_reset_q, core_reset_d;
    logic               ready_q, ready_d;
    logic               tout_exp;

`ifdef PLL_LOCK_TIMEOUT_EN
    localparam int unsigned TOUT_W = $clog2(LOCK_TIMEOUT_CYCLES) + 1;
    localparam logic [TOUT_W-1:0] TOUT_LAST = TOUT_W'(LOCK_TIMEOUT_CYCLES - 1);

    logic [TOUT_W-1:0] tout_q, tout_d;

    // Counter parks at its last value so a lock that wins over expiry leaves it armed.
    always_comb begin
        tout_d = tout_q;
        if (state_q == PLL_RST && rst_cnt_q == RST_LAST) begin
            tout_d = '0;
        end else if ((state_q == WAIT_LOCK || state_q == SETTLE) && !tout_exp) begin
            tout_d = tout_q + TOUT_W'(1);
        end
    end

    assign tout_exp = (tout_q == TOUT_LAST);
`else
    localparam bit timeout_unused = (LOCK_TIMEOUT_CYCLES != 0);
    assign tout_exp = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        stb_cnt_d = stb_cnt_q;
        fault_d   = fault_q;

        case (state_q)
            PLL_RST: begin
                if (rst_cnt_q == RST_LAST) begin
                    state_d   = WAIT_LOCK;
                    rst_cnt_d = '0;
                end else begin
                    rst_cnt_d = rst_cnt_q + RST_W'(1);
                end
            end
            WAIT_LOCK: begin
                if (locked_s) begin
                    state_d   = SETTLE;
                    stb_cnt_d = '0;
                end else if (tout_exp) begin
                    state_d   = PLL_RST;
                    rst_cnt_d = '0;
                    fault_d   = fault_sat_inc(fault_q);
                end
            end
            SETTLE: begin
                if (locked_s && stb_cnt_q == STB_LAST) begin
                    state_d = RUN;
                end else if (tout_exp) begin
                    state_d   = PLL_RST;
                    rst_cnt_d = '0;
                    fault_d   = fault_sat_inc(fault_q);
                end else if (locked_s) begin
                    stb_cnt_d = stb_cnt_q + STB_W'(1);
                end else begin
                    state_d   = WAIT_LOCK;
                    stb_cnt_d = '0;
                end
            end
            RUN: begin
                if (!locked_s) begin
                    state_d   = PLL_RST;
                    rst_cnt_d = '0;
                    fault_d   = fault_sat_inc(fault_q);
                end else if (relock_req) begin
                    state_d   = PLL_RST;
                    rst_cnt_d = '0;
                end
            end
            default: begin
                state_d   = PLL_RST;
                rst_cnt_d = '0;
            end
        endcase

        // Outputs are decoded from the next state so they register alongside it.
        pll_rst_d    = (state_d == PLL_RST);
        core_reset_d = (state_d != RUN);
        ready_d      = (state_d == RUN);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= PLL_RST;
            rst_cnt_q    <= '0;
            stb_cnt_q    <= '0;
            fault_q      <= '0;
            pll_rst_q    <= 1'b1;
            core_reset_q <= 1'b1;
            ready_q      <= 1'b0;
`ifdef PLL_LOCK_TIMEOUT_EN
            tout_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            rst_cnt_q    <= rst_cnt_d;
            stb_cnt_q    <= stb_cnt_d;
            fault_q      <= fault_d;
            pll_rst_q    <= pll_rst_d;
            core_reset_q <= core_reset_d;
            ready_q      <= ready_d;
`ifdef PLL_LOCK_TIMEOUT_EN
            tout_q       <= tout_d;
`endif
        end
    end

    assign pll_rst     = pll_rst_q;
    assign core_reset  = core_reset_q;
    assign ready       = ready_q;
    assign state       = state_q;
    assign fault_count = fault_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer (PLL_RST=3, STABLE=16, TIMEOUT=64);
// the timeout scenario is included when PLL_LOCK_TIMEOUT_EN is defined.
module tb_pll_reset_sequencer;

    logic       clock = 1'b0;
    logic       reset;
    logic       pll_locked;
    logic       relock_req;
    logic       pll_rst;
    logic       core_reset;
    logic       ready;
    logic [1:0] state;
    logic [7:0] fault_count;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    pll_reset_sequencer #(
        .PLL_RST_CYCLES     (3),
        .LOCK_STABLE_CYCLES (16),
        .LOCK_TIMEOUT_CYCLES(64)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .pll_locked (pll_locked),
        .relock_req (relock_req),
        .pll_rst    (pll_rst),
        .core_reset (core_reset),
        .ready      (ready),
        .state      (state),
        .fault_count(fault_count)
    );

    always #5 clock = ~clock;

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic step(input int unsigned n);
        repeat (n) @(negedge clock);
    endtask

    task automatic test_reset;
        reset = 1'b1; pll_locked = 1'b0; relock_req = 1'b0;
        step(3);
        checks++; if (state !== 2'd0) begin failures++; $display("FAIL rst_state: got %0d expected 0", state); end
        checks++; if (pll_rst !== 1'b1) begin failures++; $display("FAIL rst_pll_rst: got %b expected 1", pll_rst); end
        checks++; if (core_reset !== 1'b1) begin failures++; $display("FAIL rst_core_reset: got %b expected 1", core_reset); end
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL rst_ready: got %b expected 0", ready); end
        checks++; if (fault_count !== 8'd0) begin failures++; $display("FAIL rst_fault: got %0d expected 0", fault_count); end
    endtask

    task automatic test_clean_start;
        int unsigned hi = 0;
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (pll_rst === 1'b1) hi++;
            step(1);
        end
        checks++; if (hi != 3) begin failures++; $display("FAIL start_pulse_width: got %0d expected 3", hi); end
        checks++; if (state !== 2'd1) begin failures++; $display("FAIL start_wait_lock: got %0d expected 1", state); end
        step(4);
        pll_locked = 1'b1;
        step(2);
        checks++; if (state !== 2'd1) begin failures++; $display("FAIL start_sync_delay: got %0d expected 1", state); end
        step(1);
        checks++; if (state !== 2'd2) begin failures++; $display("FAIL start_settle: got %0d expected 2", state); end
        step(15);
        checks++; if (core_reset !== 1'b1) begin failures++; $display("FAIL start_early_release: got %b expected 1", core_reset); end
        step(1);
        checks++; if (core_reset !== 1'b0) begin failures++; $display("FAIL start_core_reset: got %b expected 0", core_reset); end
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL start_ready: got %b expected 1", ready); end
        checks++; if (state !== 2'd3) begin failures++; $display("FAIL start_run: got %0d expected 3", state); end
        checks++; if (fault_count !== 8'd0) begin failures++; $display("FAIL start_fault: got %0d expected 0", fault_count); end
    endtask

    task automatic test_lock_loss;
        pll_locked = 1'b0;
        step(2);
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL loss_early: got %b expected 1", ready); end
        step(1);
        checks++; if (pll_rst !== 1'b1) begin failures++; $display("FAIL loss_pll_rst: got %b expected 1", pll_rst); end
        checks++; if (core_reset !== 1'b1) begin failures++; $display("FAIL loss_core_reset: got %b expected 1", core_reset); end
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL loss_ready: got %b expected 0", ready); end
        checks++; if (fault_count !== 8'd1) begin failures++; $display("FAIL loss_fault: got %0d expected 1", fault_count); end
    endtask

    task automatic test_settle_glitch;
        step(5);
        checks++; if (state !== 2'd1) begin failures++; $display("FAIL glitch_wait: got %0d expected 1", state); end
        pll_locked = 1'b1;
        step(3);
        checks++; if (state !== 2'd2) begin failures++; $display("FAIL glitch_settle: got %0d expected 2", state); end
        step(8);
        pll_locked = 1'b0;
        step(4);
        checks++; if (state !== 2'd1) begin failures++; $display("FAIL glitch_back_wait: got %0d expected 1", state); end
        pll_locked = 1'b1;
        step(18);
        checks++; if (state !== 2'd2) begin failures++; $display("FAIL glitch_restart: got %0d expected 2", state); end
        step(1);
        checks++; if (state !== 2'd3) begin failures++; $display("FAIL glitch_run: got %0d expected 3", state); end
        checks++; if (fault_count !== 8'd1) begin failures++; $display("FAIL glitch_fault: got %0d expected 1", fault_count); end
    endtask

    task automatic test_relock;
        int unsigned hi = 0;
        relock_req = 1'b1;
        step(1);
        relock_req = 1'b0;
        checks++; if (state !== 2'd0) begin failures++; $display("FAIL relock_state: got %0d expected 0", state); end
        checks++; if (fault_count !== 8'd1) begin failures++; $display("FAIL relock_fault: got %0d expected 1", fault_count); end
        for (int i = 0; i < 5; i++) begin
            if (pll_rst === 1'b1) hi++;
            step(1);
        end
        checks++; if (hi != 3) begin failures++; $display("FAIL relock_pulse_width: got %0d expected 3", hi); end
        step(16);
        checks++; if (state !== 2'd3) begin failures++; $display("FAIL relock_rerun: got %0d expected 3", state); end
        pll_locked = 1'b0;
        step(2);
        relock_req = 1'b1;
        step(1);
        relock_req = 1'b0;
        checks++; if (pll_rst !== 1'b1) begin failures++; $display("FAIL coinc_pll_rst: got %b expected 1", pll_rst); end
        checks++; if (fault_count !== 8'd2) begin failures++; $display("FAIL coinc_fault: got %0d expected 2", fault_count); end
        hi = 0;
        for (int i = 0; i < 8; i++) begin
            if (pll_rst === 1'b1) hi++;
            step(1);
        end
        checks++; if (hi != 3) begin failures++; $display("FAIL coinc_single_pulse: got %0d expected 3", hi); end
        checks++; if (fault_count !== 8'd2) begin failures++; $display("FAIL coinc_fault_once: got %0d expected 2", fault_count); end
    endtask

    task automatic test_relock_in_settle;
        pll_locked = 1'b1;
        step(3);
        checks++; if (state !== 2'd2) begin failures++; $display("FAIL settle_relock_pre: got %0d expected 2", state); end
        relock_req = 1'b1;
        step(1);
        relock_req = 1'b0;
        checks++; if (state !== 2'd2) begin failures++; $display("FAIL settle_relock_ignored: got %0d expected 2", state); end
        checks++; if (pll_rst !== 1'b0) begin failures++; $display("FAIL settle_relock_pll_rst: got %b expected 0", pll_rst); end
    endtask

    task automatic test_reset_in_settle;
        step(2);
        reset = 1'b1;
        step(1);
        checks++; if (state !== 2'd0) begin failures++; $display("FAIL midreset_state: got %0d expected 0", state); end
        checks++; if (pll_rst !== 1'b1) begin failures++; $display("FAIL midreset_pll_rst: got %b expected 1", pll_rst); end
        checks++; if (fault_count !== 8'd0) begin failures++; $display("FAIL midreset_fault: got %0d expected 0", fault_count); end
        checks++; if (core_reset !== 1'b1) begin failures++; $display("FAIL midreset_core_reset: got %b expected 1", core_reset); end
        reset = 1'b0;
    endtask

`ifdef PLL_LOCK_TIMEOUT_EN
    task automatic test_timeout;
        reset = 1'b1; pll_locked = 1'b0;
        step(2);
        reset = 1'b0;
        step(66);
        checks++; if (state !== 2'd1) begin failures++; $display("FAIL tout1_pre: got %0d expected 1", state); end
        step(1);
        checks++; if (pll_rst !== 1'b1) begin failures++; $display("FAIL tout1_pll_rst: got %b expected 1", pll_rst); end
        checks++; if (fault_count !== 8'd1) begin failures++; $display("FAIL tout1_fault: got %0d expected 1", fault_count); end
        step(66);
        checks++; if (state !== 2'd1) begin failures++; $display("FAIL tout2_pre: got %0d expected 1", state); end
        step(1);
        checks++; if (fault_count !== 8'd2) begin failures++; $display("FAIL tout2_fault: got %0d expected 2", fault_count); end
        step(67 * 253);
        checks++; if (fault_count !== 8'd255) begin failures++; $display("FAIL tout_255: got %0d expected 255", fault_count); end
        checks++; if (state !== 2'd0) begin failures++; $display("FAIL tout_255_state: got %0d expected 0", state); end
        step(67);
        checks++; if (fault_count !== 8'd255) begin failures++; $display("FAIL tout_saturate: got %0d expected 255", fault_count); end
        checks++; if (pll_rst !== 1'b1) begin failures++; $display("FAIL tout_sat_pulse: got %b expected 1", pll_rst); end
    endtask
`endif

    initial begin
        test_reset();
        test_clean_start();
        test_lock_loss();
        test_settle_glitch();
        test_relock();
        test_relock_in_settle();
        test_reset_in_settle();
`ifdef PLL_LOCK_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
